// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 64-point FFT output.
// Two ping-pong banks let back-to-back frames stream through without a stall.
module fft_bitrev_reorder #(
    parameter int WIDTH = 12,
    parameter int LANES = 16,
    parameter int NPTS  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_re [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im [0:LANES-1],
    output logic                    dout_valid,
    output logic                    dout_sof,
    output logic [1:0]              dout_beat,
    output logic signed [WIDTH-1:0] dout_re [0:LANES-1],
    output logic signed [WIDTH-1:0] dout_im [0:LANES-1]
);

    localparam int MEM_DEPTH = 2 * NPTS;

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    // Frame storage: address = {bank, natural index}
    logic signed [WIDTH-1:0] r_mem_re [0:MEM_DEPTH-1];
    logic signed [WIDTH-1:0] r_mem_im [0:MEM_DEPTH-1];

    logic [1:0] r_wr_beat;
    logic       r_wr_bank;
    logic [1:0] r_full;

    state_t     r_state;
    logic [1:0] r_rd_beat;
    logic       r_rd_bank;

    logic                    r_dout_valid;
    logic                    r_dout_sof;
    logic [1:0]              r_dout_beat;
    logic signed [WIDTH-1:0] r_dout_re [0:LANES-1];
    logic signed [WIDTH-1:0] r_dout_im [0:LANES-1];

    logic       w_wr_done;
    logic [1:0] w_set_full;
    logic [1:0] w_clr_full;
    state_t     w_state_nxt;
    logic       w_rd_en;
    logic [1:0] w_rd_beat_sel;
    logic [1:0] w_rd_beat_nxt;
    logic       w_rd_bank_nxt;

    assign w_wr_done  = din_valid && (r_wr_beat == 2'd3);
    assign w_set_full = w_wr_done ? (2'b01 << r_wr_bank) : 2'b00;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            r_wr_beat <= 2'd0;
            r_wr_bank <= 1'b0;
        end else if (din_valid) begin
            r_wr_beat <= r_wr_beat + 2'd1;
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // NOTE: the frame memories carry no reset; stale contents are never
    // read because the full flags are cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && din_valid) begin
            for (int l = 0; l < LANES; l++) begin
                r_mem_re[{r_wr_bank, bitrev6({r_wr_beat, 4'(l)})}] <= din_re[l];
                r_mem_im[{r_wr_bank, bitrev6({r_wr_beat, 4'(l)})}] <= din_im[l];
            end
        end
    end

    // Write completion and read drain always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_set_full[b]) begin
                    r_full[b] <= 1'b1;
                end else if (w_clr_full[b]) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_beat <= 2'd0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_beat <= w_rd_beat_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    // r_rd_bank always names the next bank due out; banks fill in the same
    // alternating order, so no arbitration between full flags is needed.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_rd_en       = 1'b0;
        w_rd_beat_sel = r_rd_beat;
        w_rd_beat_nxt = r_rd_beat;
        w_rd_bank_nxt = r_rd_bank;
        w_clr_full    = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_rd_en       = 1'b1;
                    w_rd_beat_sel = 2'd0;
                    w_rd_beat_nxt = 2'd1;
                    w_state_nxt   = S_READ;
                end
            end
            S_READ: begin
                w_rd_en       = 1'b1;
                w_rd_beat_nxt = r_rd_beat + 2'd1;
                if (r_rd_beat == 2'd3) begin
                    w_clr_full    = 2'b01 << r_rd_bank;
                    w_rd_bank_nxt = ~r_rd_bank;
                    w_state_nxt   = r_full[~r_rd_bank] ? S_READ : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
            r_dout_beat  <= 2'd0;
            for (int l = 0; l < LANES; l++) begin
                r_dout_re[l] <= '0;
                r_dout_im[l] <= '0;
            end
        end else begin
            r_dout_valid <= w_rd_en;
            r_dout_sof   <= w_rd_en && (w_rd_beat_sel == 2'd0);
            if (w_rd_en) begin
                r_dout_beat <= w_rd_beat_sel;
                for (int l = 0; l < LANES; l++) begin
                    r_dout_re[l] <= r_mem_re[{r_rd_bank, w_rd_beat_sel, 4'(l)}];
                    r_dout_im[l] <= r_mem_im[{r_rd_bank, w_rd_beat_sel, 4'(l)}];
                end
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_sof   = r_dout_sof;
    assign dout_beat  = r_dout_beat;
    assign dout_re    = r_dout_re;
    assign dout_im    = r_dout_im;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder: a frame-level reference model
// predicts every output beat and the cycle on which it must appear.
module tb_fft_bitrev_reorder;

    localparam int W = 12;
    localparam int L = 16;
    localparam int PW = W * L;

    logic                clk = 1'b0;
    logic                rst;
    logic                din_valid;
    logic signed [W-1:0] din_re [0:L-1];
    logic signed [W-1:0] din_im [0:L-1];
    logic                dout_valid;
    logic                dout_sof;
    logic [1:0]          dout_beat;
    logic signed [W-1:0] dout_re [0:L-1];
    logic signed [W-1:0] dout_im [0:L-1];

    fft_bitrev_reorder #(.WIDTH(W), .LANES(L), .NPTS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_re     (din_re),
        .din_im     (din_im),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_beat  (dout_beat),
        .dout_re    (dout_re),
        .dout_im    (dout_im)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < 6; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: rebuild each frame in natural order from the input
    // beats, then schedule its four output beats one edge after completion.
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [PW-1:0] re;
        logic [PW-1:0] im;
        logic        sof;
        logic [1:0]  beat;
    } exp_t;

    exp_t            exp_q[$];
    int              cyc = 0;
    int              m_beat = 0;
    int              last_sched = 0;
    bit              rst_last = 0;
    bit              started = 0;
    logic signed [W-1:0] nat_re [64];
    logic signed [W-1:0] nat_im [64];

    always @(posedge clk) begin
        exp_t e;
        int   t;
        cyc++;
        started  = 1;
        rst_last = rst;
        if (rst) begin
            m_beat = 0;
            last_sched = 0;
            exp_q.delete();
        end else if (din_valid) begin
            for (int l = 0; l < L; l++) begin
                nat_re[brev(16 * m_beat + l)] = din_re[l];
                nat_im[brev(16 * m_beat + l)] = din_im[l];
            end
            m_beat++;
            if (m_beat == 4) begin
                m_beat = 0;
                t = (cyc + 1 > last_sched + 1) ? cyc + 1 : last_sched + 1;
                for (int b = 0; b < 4; b++) begin
                    e.cyc  = t + b;
                    e.sof  = (b == 0);
                    e.beat = 2'(b);
                    for (int l = 0; l < L; l++) begin
                        e.re[l*W +: W] = nat_re[16 * b + l];
                        e.im[l*W +: W] = nat_im[16 * b + l];
                    end
                    exp_q.push_back(e);
                end
                last_sched = t + 3;
            end
        end
    end

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        exp_t          e;
        logic [PW-1:0] pre;
        logic [PW-1:0] pim;
        if (started) begin
            for (int l = 0; l < L; l++) begin
                pre[l*W +: W] = dout_re[l];
                pim[l*W +: W] = dout_im[l];
            end
            if (rst_last) begin
                check("rst_sof", PW'(dout_sof), '0);
                check("rst_beat", PW'(dout_beat), '0);
                check("rst_re", pre, '0);
                check("rst_im", pim, '0);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("valid", PW'(dout_valid), PW'(1));
                check("sof", PW'(dout_sof), PW'(e.sof));
                check("beat", PW'(dout_beat), PW'(e.beat));
                check("re", pre, e.re);
                check("im", pim, e.im);
            end else begin
                check("idle_valid", PW'(dout_valid), '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic signed [W-1:0] f_re [64];
    logic signed [W-1:0] f_im [64];

    task automatic fill_ramp(input int base);
        for (int i = 0; i < 64; i++) begin
            f_re[i] = W'(base + i);
            f_im[i] = W'(-(base + i));
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            f_re[i] = W'($urandom);
            f_im[i] = W'($urandom);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nbeats beats of the natural-order frame f_* in bit-reversed order.
    task automatic send_frame(input int nbeats, input int max_gap);
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < L; l++) begin
                din_re[l] = f_re[brev(16 * b + l)];
                din_im[l] = f_im[brev(16 * b + l)];
            end
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            idle($urandom_range(max_gap, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 1'b0;
        for (int l = 0; l < L; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single ramp frame
        fill_ramp(0);
        send_frame(4, 0);
        idle(8);

        // Three back-to-back frames
        for (int f = 0; f < 3; f++) begin
            fill_ramp(64 * f);
            send_frame(4, 0);
        end
        idle(8);

        // Gapped random frames
        for (int f = 0; f < 6; f++) begin
            fill_rand();
            send_frame(4, 3);
        end
        idle(8);

        // Extremes
        for (int i = 0; i < 64; i++) begin
            f_re[i] = 12'sd2047;
            f_im[i] = -12'sd2048;
        end
        send_frame(4, 0);
        idle(8);

        // Reset mid-input, with din_valid asserted during reset
        fill_rand();
        send_frame(3, 0);
        rst = 1'b1;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        fill_ramp(100);
        send_frame(4, 0);
        idle(8);

        // Reset on output beat 1
        fill_rand();
        send_frame(4, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        fill_rand();
        send_frame(4, 1);
        fill_rand();
        send_frame(4, 0);
        idle(10);

        check("drain", PW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
